// File: rtl/kb_event_buf_pkg.sv
// ============================================================================
// Module  : kb_event_buf_pkg
// Brief   : Shared PS/2 prefix bytes, event field layout and decoder state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package kb_event_buf_pkg;

  localparam logic [7:0] KB_PFX_EXT = 8'hE0;
  localparam logic [7:0] KB_PFX_BRK = 8'hF0;

  localparam int EV_EXT = 9;
  localparam int EV_BRK = 8;
  localparam int EV_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  // Keyboard controller responses (ack, BAT, echo, errors) are not key actions
  function automatic logic kb_is_ctrl_resp(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/kb_fifo_fwft.sv
// ============================================================================
// Module  : kb_fifo_fwft
// Brief   : First-word-fall-through FIFO with extra-MSB pointers and level count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kb_fifo_fwft #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              w_do_rd;
  logic              w_do_wr;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                 (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_do_rd = rd && !empty;
  assign w_do_wr = wr && (!full || w_do_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
        r_wr_ptr                    <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/kb_event_buf.sv
// ============================================================================
// Module  : kb_event_buf
// Brief   : PS/2 E0/F0 prefix decoder with typematic filter feeding an event FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kb_event_buf
  import kb_event_buf_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int REPORT_BREAK = 1,
  parameter int TYPE_FILTER  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [7:0]      rx_dout,
  input  logic            rd_event,
  input  logic            clr_overflow,
  output logic [9:0]      event_data,
  output logic            buf_empty,
  output logic            buf_full,
  output logic            overflow,
  output logic [ADDR_W:0] level
);

  kb_state_t  r_state;
  kb_state_t  w_state_nxt;
  logic       w_ev_valid;
  logic       w_ev_ext;
  logic       w_ev_brk;
  logic       r_held_valid;
  logic       r_held_ext;
  logic [7:0] r_held_code;
  logic       w_held_match;
  logic       w_filtered;
  logic       w_report;
  logic       w_write;
  logic       w_drop;
  logic       r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ev_valid  = 1'b0;
    w_ev_ext    = 1'b0;
    w_ev_brk    = 1'b0;
    if (rx_done_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_dout == KB_PFX_EXT)      w_state_nxt = ST_EXT;
          else if (rx_dout == KB_PFX_BRK) w_state_nxt = ST_BRK;
          else if (!kb_is_ctrl_resp(rx_dout)) w_ev_valid = 1'b1;
        end
        ST_EXT: begin
          if (rx_dout == KB_PFX_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (rx_dout == KB_PFX_EXT) w_state_nxt = ST_EXT;
          else begin
            w_ev_valid  = 1'b1;
            w_ev_ext    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_dout == KB_PFX_BRK)      w_state_nxt = ST_BRK;
          else if (rx_dout == KB_PFX_EXT) w_state_nxt = ST_EXT;
          else begin
            w_ev_valid  = 1'b1;
            w_ev_brk    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (rx_dout == KB_PFX_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (rx_dout == KB_PFX_EXT) w_state_nxt = ST_EXT;
          else begin
            w_ev_valid  = 1'b1;
            w_ev_ext    = 1'b1;
            w_ev_brk    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_held_match = r_held_valid && (r_held_ext == w_ev_ext) && (r_held_code == rx_dout);
  assign w_filtered   = (TYPE_FILTER != 0) && !w_ev_brk && w_held_match;
  assign w_report     = !w_ev_brk || (REPORT_BREAK != 0);
  assign w_write      = w_ev_valid && w_report && !w_filtered;
  assign w_drop       = w_write && buf_full && !rd_event;

  // Held key tracks decoded actions even when breaks are not reported
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held_valid <= 1'b0;
      r_held_ext   <= 1'b0;
      r_held_code  <= '0;
    end else if (w_ev_valid) begin
      if (!w_ev_brk) begin
        r_held_valid <= 1'b1;
        r_held_ext   <= w_ev_ext;
        r_held_code  <= rx_dout;
      end else if (w_held_match) begin
        r_held_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (clr_overflow) r_overflow <= 1'b0;
  end

  assign overflow = r_overflow;

  kb_fifo_fwft #(
    .DATA_W (EV_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (w_write),
    .din   ({w_ev_ext, w_ev_brk, rx_dout}),
    .rd    (rd_event),
    .dout  (event_data),
    .empty (buf_empty),
    .full  (buf_full),
    .level (level)
  );

endmodule

`default_nettype wire
